// File: rtl/eq_gain_sequencer_pkg.sv
// Shared constants for the EQ gain sequencer: state encoding and
// register bit positions, also consumed by software header generation.
package eq_gain_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int CTRL_TRIG_BIT  = 31;
  localparam int CTRL_CLR_BIT   = 30;
  localparam int CTRL_START_LO  = 20;
  localparam int CTRL_STOP_LO   = 0;
  localparam int CTRL_RANGE_W   = 10;

  localparam int STAT_BUSY_BIT  = 31;
  localparam int STAT_OVR_BIT   = 30;
  localparam int STAT_STATE_LO  = 28;
  localparam int STAT_CNT_LO    = 0;
  localparam int STAT_CNT_W     = 16;

endpackage

// File: rtl/eq_gain_addr_gen.sv
// Range latch and modulo-2^CHAN_BITS channel counter.
// Ports: i_latch captures start/stop, i_load/i_inc drive o_addr,
// o_last flags the counter sitting on the latched stop channel.
module eq_gain_addr_gen
  import eq_gain_sequencer_pkg::*;
#(
  parameter int CHAN_BITS = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_latch,
  input  logic [CHAN_BITS-1:0] i_start,
  input  logic [CHAN_BITS-1:0] i_stop,
  input  logic                 i_load,
  input  logic                 i_inc,
  output logic [CHAN_BITS-1:0] o_addr,
  output logic                 o_last
);

  logic [CHAN_BITS-1:0] r_start;
  logic [CHAN_BITS-1:0] r_stop;
  logic [CHAN_BITS-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_start <= '0;
      r_stop  <= '0;
      r_cnt   <= '0;
    end else begin
      if (i_latch) begin
        r_start <= i_start;
        r_stop  <= i_stop;
      end
      // Natural overflow gives the 1023->0 wrap.
      if (i_load)
        r_cnt <= r_start;
      else if (i_inc)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_addr = r_cnt;
  assign o_last = (r_cnt == r_stop);

endmodule

// File: rtl/eq_gain_sequencer.sv
// Loads one gain into a contiguous (wrapping) channel range of the
// coefficient RAM, one write per cycle, started by a frame sync.
// Ports: ctrl_reg/gain_reg software words, sync_in frame pulse,
// coeff_we/addr/data RAM write port, status readback.
module eq_gain_sequencer
  import eq_gain_sequencer_pkg::*;
#(
  parameter int CHAN_BITS = 10,
  parameter int GAIN_W    = 16
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  input  logic [31:0]          ctrl_reg,
  input  logic [31:0]          gain_reg,
  input  logic                 sync_in,
  output logic                 coeff_we,
  output logic [CHAN_BITS-1:0] coeff_addr,
  output logic [GAIN_W-1:0]    coeff_data,
  output logic [31:0]          status
);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  logic              r_init;
  logic              r_trig_q;
  logic              r_trig_p;
  logic              r_clr_q;
  logic              r_clr_p;
  logic              w_trig_edge;
  logic              w_clr_edge;
  state_t            r_state;
  logic              r_we;
  logic [GAIN_W-1:0] r_data;
  logic [GAIN_W-1:0] r_gain;
  logic              r_ovr;
  logic [15:0]       r_cnt;
  logic              w_latch;
  logic              w_load;
  logic              w_inc;
  logic              w_last;
  logic              w_busy;
  logic              w_unused;

  // Assert immediately, release on a clock edge.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n)
      r_rst_sync <= 2'b00;
    else
      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // On the first edge after reset the previous-value registers copy
  // the live bit, so a level already high is not seen as an edge.
  always_ff @(posedge user_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_init   <= 1'b0;
      r_trig_q <= 1'b0;
      r_trig_p <= 1'b0;
      r_clr_q  <= 1'b0;
      r_clr_p  <= 1'b0;
    end else begin
      r_init   <= 1'b1;
      r_trig_q <= ctrl_reg[CTRL_TRIG_BIT];
      r_clr_q  <= ctrl_reg[CTRL_CLR_BIT];
      r_trig_p <= r_init ? r_trig_q : ctrl_reg[CTRL_TRIG_BIT];
      r_clr_p  <= r_init ? r_clr_q  : ctrl_reg[CTRL_CLR_BIT];
    end
  end

  assign w_trig_edge = r_trig_q & ~r_trig_p;
  assign w_clr_edge  = r_clr_q  & ~r_clr_p;
  assign w_busy      = (r_state != ST_IDLE);

  assign w_latch = (r_state == ST_IDLE)  && w_trig_edge;
  assign w_load  = (r_state == ST_ARMED) && sync_in;
  assign w_inc   = (r_state == ST_WRITE) && !w_last;

  eq_gain_addr_gen #(
    .CHAN_BITS (CHAN_BITS)
  ) u_addr_gen (
    .i_clk   (user_clk),
    .i_rst_n (w_rst_n),
    .i_latch (w_latch),
    .i_start (ctrl_reg[CTRL_START_LO +: CHAN_BITS]),
    .i_stop  (ctrl_reg[CTRL_STOP_LO  +: CHAN_BITS]),
    .i_load  (w_load),
    .i_inc   (w_inc),
    .o_addr  (coeff_addr),
    .o_last  (w_last)
  );

  always_ff @(posedge user_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_data  <= '0;
      r_gain  <= '0;
      r_ovr   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // Setting wins over a coincident clear.
      if (w_trig_edge && w_busy)
        r_ovr <= 1'b1;
      else if (w_clr_edge)
        r_ovr <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_trig_edge) begin
            r_gain  <= gain_reg[GAIN_W-1:0];
            r_state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (sync_in) begin
            r_we    <= 1'b1;
            r_data  <= r_gain;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_last) begin
            r_we    <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_cnt   <= r_cnt + 16'd1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign coeff_we   = r_we;
  assign coeff_data = r_data;

  assign status = {w_busy, r_ovr, r_state, 12'h000, r_cnt};

  assign w_unused = ^{ctrl_reg, gain_reg};

endmodule

// File: doc/eq_gain_sequencer.md
EQ_GAIN_SEQUENCER -- requirements
Module: eq_gain_sequencer

Interface
REQ-001 SHALL have parameter CHAN_BITS, default 10, channel address width (1024 channels).
REQ-002 SHALL have parameter GAIN_W, default 16, gain coefficient width (unsigned).
REQ-003 SHALL have port user_clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port user_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ctrl_reg  input  32  software control word: [31] trigger, [30] clear_err, [29:20] start_ch, [9:0] stop_ch.
REQ-006 SHALL have port gain_reg  input  32  software gain word; [GAIN_W-1:0] used, upper bits ignored.
REQ-007 SHALL have port sync_in  input  1  one-cycle frame-sync pulse from FFT datapath.
REQ-008 SHALL have port coeff_we  output  1  coefficient RAM write enable.
REQ-009 SHALL have port coeff_addr  output  CHAN_BITS  coefficient RAM channel address.
REQ-010 SHALL have port coeff_data  output  GAIN_W  coefficient RAM write data.
REQ-011 SHALL have port status  output  32  readback: [31] busy, [30] overrun, [29:28] state, [15:0] completed-load count.

Function
REQ-012 SHALL register ctrl_reg[31] and ctrl_reg[30] once and detect rising edges; trigger edge = 0->1 on registered bit 31.
REQ-013 SHALL use states IDLE(0), ARMED(1), WRITE(2), DONE(3), encoded on status[29:28].
REQ-014 IDLE: on trigger edge, SHALL latch start_ch, stop_ch, gain_reg[GAIN_W-1:0] and go ARMED next cycle.
REQ-015 ARMED: SHALL wait for sync_in; on sync_in high go WRITE; first write asserted the cycle after sync_in sampled.
REQ-016 WRITE: SHALL assert coeff_we for one address per cycle, starting at latched start_ch, incrementing modulo 2^CHAN_BITS, coeff_data = latched gain.
REQ-017 WRITE SHALL end after the cycle writing stop_ch; if stop_ch < start_ch the range wraps through 1023->0; start_ch == stop_ch writes exactly one channel.
REQ-018 Total writes per load SHALL equal ((stop_ch - start_ch) mod 2^CHAN_BITS) + 1, with no gaps and no extra we cycles.
REQ-019 DONE: SHALL increment load count (16-bit, wraps 0xFFFF->0) and return to IDLE the next cycle.
REQ-020 busy (status[31]) SHALL be high in ARMED, WRITE, DONE; low in IDLE.
REQ-021 Trigger edge while busy SHALL be ignored (latched values unchanged) and SHALL set sticky overrun.
REQ-022 clear_err edge SHALL clear overrun; simultaneous trigger-while-busy and clear_err SHALL leave overrun set.
REQ-023 sync_in during WRITE or IDLE SHALL have no effect.
REQ-024 Changes to gain_reg or ctrl_reg range bits after latch SHALL not affect the load in progress.
REQ-025 coeff_addr and coeff_data SHALL be registered outputs; coeff_addr holds last value when coeff_we low.

Reset
REQ-026 On user_rst_n low: state IDLE, coeff_we 0, coeff_addr 0, coeff_data 0, overrun 0, load count 0, edge-detect registers 0, immediately (asynchronous).
REQ-027 Reset mid-WRITE SHALL abort the load with no further writes; deassertion SHALL be synchronised to user_clk so first post-reset edge is clean.
REQ-028 A trigger bit already high at reset release SHALL NOT count as an edge.

Structure
REQ-029 Shared package SHALL hold state encoding constants and ctrl_reg/status bit-field positions, reused by software-side header generation.
REQ-030 One sub-module natural: eq_gain_addr_gen (start/stop latch, modulo-2^CHAN_BITS counter, last-address flag).
REQ-031 Block SHALL be single-clock; crossing from the software-register domain is outside this block.

Verification
REQ-032 start 5, stop 8, gain 0x0100, trigger, sync after 10 cycles -> we high 4 consecutive cycles, addr 5,6,7,8, data 0x0100; count = 1.
REQ-033 start 1022, stop 1, trigger, sync -> addr 1022,1023,0,1; exactly 4 writes.
REQ-034 start = stop = 300 -> exactly one write at 300, then IDLE.
REQ-035 second trigger during WRITE -> no change to sequence, overrun = 1; clear_err edge -> overrun = 0.
REQ-036 user_rst_n low at 3rd write cycle -> we 0 same cycle, state IDLE, count 0; trigger high through reset release -> no load starts.
REQ-037 gain_reg changed during ARMED -> written data equals value latched at trigger.
